// File: rtl/host_link_pkg.sv
// Shared types for the host link agent: FSM states, data width and controller phase codes.
package host_link_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARMED,
        ST_START,
        ST_LEAD,
        ST_SEND,
        ST_WAIT,
        ST_CAPTURE,
        ST_DRAIN
    } link_state_e;

    typedef enum logic [1:0] {
        PH_LOAD = 2'b00,
        PH_RUN  = 2'b01,
        PH_OUT  = 2'b10,
        PH_IDLE = 2'b11
    } ctrl_phase_e;

endpackage

// File: rtl/link_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module link_sdp_ram #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/host_link_agent.sv
// Host-side peer of the controller load/unload handshake: buffer an image, burst it out,
// capture the controller's output stream and drain it on a ready/valid result port.
module host_link_agent
    import host_link_pkg::*;
#(
    parameter int unsigned LOAD_DEPTH  = 1024,
    parameter int unsigned RES_DEPTH   = 1025,
    parameter int unsigned LEAD_CYCLES = 2,    // must be >= 2: image RAM read is issued one cycle ahead
    parameter int unsigned RD_LATENCY  = 1     // must be >= 1: the rise cycle is always discarded
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              run_start,
    input  logic [3:0]        cfg_n_cores,
    output logic [3:0]        n_cores,
    output logic [DATA_W-1:0] com_data_in,
    output logic              data_write_start,
    output logic              data_write_done,
    input  logic [DATA_W-1:0] com_data_out,
    input  logic [1:0]        state,
    input  logic              output_write_start,
    input  logic              output_write_done,
    output logic              rs_valid,
    input  logic              rs_ready,
    output logic [DATA_W-1:0] rs_data,
    output logic              rs_last,
    output logic              busy,
    output logic              error
);

    localparam int unsigned LC_W = $clog2(LOAD_DEPTH + 1);
    localparam int unsigned LA_W = $clog2(LOAD_DEPTH);
    localparam int unsigned RC_W = $clog2(RES_DEPTH + 1);
    localparam int unsigned RA_W = $clog2(RES_DEPTH);
    localparam int unsigned CY_W = $clog2(LOAD_DEPTH + LEAD_CYCLES + 1);
    localparam int unsigned DC_W = $clog2(RD_LATENCY + 1);

    link_state_e       state_q, state_d;
    logic [LC_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [CY_W-1:0]   cyc_q, cyc_d;
    logic [RC_W-1:0]   res_cnt_q, res_cnt_d;
    logic [RC_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DC_W-1:0]   disc_q, disc_d;
    logic              pend_q, pend_d;
    logic              ows_q;
    logic              ld_ready_q, ld_ready_d;
    logic [3:0]        n_cores_q, n_cores_d;
    logic [DATA_W-1:0] com_q, com_d;
    logic              dws_q, dws_d;
    logic              dwd_q, dwd_d;
    logic              rs_valid_q, rs_valid_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic              rs_last_q, rs_last_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;

    logic              img_we, res_we, res_re;
    logic [DATA_W-1:0] img_rdata, res_rdata;
    logic [CY_W-1:0]   last_cyc;
    logic              rise, out_free;

    link_sdp_ram #(.DW(DATA_W), .DEPTH(LOAD_DEPTH)) u_img_ram (
        .clk   (clk),
        .we    (img_we),
        .waddr (LA_W'(ld_cnt_q)),
        .wdata (ld_data),
        .re    (1'b1),
        .raddr (LA_W'(cyc_q - CY_W'(LEAD_CYCLES - 2))),
        .rdata (img_rdata)
    );

    link_sdp_ram #(.DW(DATA_W), .DEPTH(RES_DEPTH)) u_res_ram (
        .clk   (clk),
        .we    (res_we),
        .waddr (RA_W'(res_cnt_q)),
        .wdata (com_data_out),
        .re    (res_re),
        .raddr (RA_W'(rd_ptr_q)),
        .rdata (res_rdata)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        cyc_d      = '0;
        res_cnt_d  = res_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        disc_d     = disc_q;
        pend_d     = pend_q;
        n_cores_d  = n_cores_q;
        error_d    = error_q;
        rs_valid_d = rs_valid_q;
        rs_data_d  = rs_data_q;
        rs_last_d  = rs_last_q;
        img_we     = 1'b0;
        res_we     = 1'b0;
        res_re     = 1'b0;
        rise       = output_write_start & ~ows_q;
        out_free   = ~rs_valid_q | rs_ready;
        last_cyc   = CY_W'(LEAD_CYCLES) + CY_W'(ld_cnt_q) - CY_W'(1);

        unique case (state_q)
            ST_IDLE, ST_FILL: begin
                if (ld_valid && ld_ready_q) begin
                    img_we   = 1'b1;
                    ld_cnt_d = ld_cnt_q + LC_W'(1);
                    if (ld_last || (ld_cnt_q == LC_W'(LOAD_DEPTH - 1))) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_ARMED: begin
                if (run_start) begin
                    n_cores_d = cfg_n_cores;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                cyc_d   = cyc_q + CY_W'(1);
                state_d = ST_LEAD;
            end
            ST_LEAD: begin
                cyc_d = cyc_q + CY_W'(1);
                if (cyc_q == CY_W'(LEAD_CYCLES - 1)) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                cyc_d = cyc_q + CY_W'(1);
                if (cyc_q == last_cyc) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rise) begin
                    disc_d    = DC_W'(1);
                    res_cnt_d = '0;
                    if (ctrl_phase_e'(state) != PH_OUT) begin
                        error_d = 1'b1;
                    end
                    state_d = output_write_done ? ST_IDLE : ST_CAPTURE;
                end else if (output_write_done) begin
                    error_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (disc_q < DC_W'(RD_LATENCY)) begin
                    disc_d = disc_q + DC_W'(1);
                    if (output_write_done) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (res_cnt_q < RC_W'(RES_DEPTH)) begin
                        res_we    = 1'b1;
                        res_cnt_d = res_cnt_q + RC_W'(1);
                    end else begin
                        error_d = 1'b1;
                    end
                    if (output_write_done) begin
                        rd_ptr_d = '0;
                        pend_d   = 1'b0;
                        state_d  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (rs_valid_q && rs_ready) begin
                    rs_valid_d = 1'b0;
                    rs_last_d  = 1'b0;
                end
                // The word sitting in the RAM output register is always index rd_ptr_q-1.
                if (pend_q && out_free) begin
                    rs_valid_d = 1'b1;
                    rs_data_d  = res_rdata;
                    rs_last_d  = (rd_ptr_q == res_cnt_q);
                    pend_d     = 1'b0;
                end
                if ((rd_ptr_q < res_cnt_q) && (!pend_q || out_free)) begin
                    res_re   = 1'b1;
                    rd_ptr_d = rd_ptr_q + RC_W'(1);
                    pend_d   = 1'b1;
                end
                if (rs_valid_q && rs_ready && rs_last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
            ld_cnt_d = '0;
        end

        ld_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
        busy_d     = !((state_d == ST_IDLE) || (state_d == ST_ARMED));
        dws_d      = (state_d == ST_START);
        com_d      = (state_d == ST_SEND) ? img_rdata : '0;
        dwd_d      = (state_d == ST_SEND) && ((cyc_q + CY_W'(1)) == last_cyc);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ld_cnt_q   <= '0;
            cyc_q      <= '0;
            res_cnt_q  <= '0;
            rd_ptr_q   <= '0;
            disc_q     <= '0;
            pend_q     <= 1'b0;
            ows_q      <= 1'b0;
            ld_ready_q <= 1'b1;
            n_cores_q  <= '0;
            com_q      <= '0;
            dws_q      <= 1'b0;
            dwd_q      <= 1'b0;
            rs_valid_q <= 1'b0;
            rs_data_q  <= '0;
            rs_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            cyc_q      <= cyc_d;
            res_cnt_q  <= res_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            disc_q     <= disc_d;
            pend_q     <= pend_d;
            ows_q      <= output_write_start;
            ld_ready_q <= ld_ready_d;
            n_cores_q  <= n_cores_d;
            com_q      <= com_d;
            dws_q      <= dws_d;
            dwd_q      <= dwd_d;
            rs_valid_q <= rs_valid_d;
            rs_data_q  <= rs_data_d;
            rs_last_q  <= rs_last_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    assign ld_ready         = ld_ready_q;
    assign n_cores          = n_cores_q;
    assign com_data_in      = com_q;
    assign data_write_start = dws_q;
    assign data_write_done  = dwd_q;
    assign rs_valid         = rs_valid_q;
    assign rs_data          = rs_data_q;
    assign rs_last          = rs_last_q;
    assign busy             = busy_q;
    assign error            = error_q;

endmodule
